// File: rtl/rv32i_mem_responder.sv
// Data-memory responder: word RAM plus CLINT-style MMIO window.
// MMIO (msip, mtimecmp, mtime mirror, commit pulses) present only
// when MEM_RESPONDER_TIMER_EN is defined; otherwise all addresses
// hit RAM and the timer outputs are tied to their idle values.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_addr / i_wr_data / i_wr_mask / i_wr_en : core request
//   o_rd_data : registered load data, one cycle latency
//   o_mtime_wr / o_mtime_din : mtime load pulse and value
//   o_mtimecmp_wr / o_mtimecmp_din : mtimecmp load pulse and value
//   o_software_interrupt : msip bit 0
module rv32i_mem_responder #(
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
  parameter int unsigned CLK_FREQ_MHZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_mask,
  input  logic        i_wr_en,
  output logic [31:0] o_rd_data,
  output logic        o_mtime_wr,
  output logic        o_mtimecmp_wr,
  output logic [63:0] o_mtime_din,
  output logic [63:0] o_mtimecmp_din,
  output logic        o_software_interrupt
);

  localparam int AW = $clog2(MEM_DEPTH);

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic [AW-1:0] ram_idx;
  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   ram_rd;
  logic          ram_hit;
  logic          ram_we;
  logic [31:0]   rd_data_d;
  logic [31:0]   rd_data_q;

  assign ram_idx = i_addr[AW+1:2];
  assign ram_rd  = mem[ram_idx];
  assign ram_we  = i_wr_en && ram_hit;

  // No reset on the array; byte lanes written independently.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we && i_wr_mask[b])
        mem[ram_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign o_rd_data = rd_data_q;

`ifdef MEM_RESPONDER_TIMER_EN

  localparam int PW =
    (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_FREQ_MHZ - 1);

  logic       mmio_hit;
  logic       mmio_we;
  logic [4:0] off;
  logic       sel_msip;
  logic       sel_cmp_lo;
  logic       sel_cmp_hi;
  logic       sel_tim_lo;
  logic       sel_tim_hi;
  logic       tick;

  logic          msip_d,    msip_q;
  logic [31:0]   cmp_lo_d,  cmp_lo_q;
  logic [31:0]   cmp_hi_d,  cmp_hi_q;
  logic [31:0]   tim_lo_d,  tim_lo_q;
  logic [31:0]   tim_hi_d,  tim_hi_q;
  logic [63:0]   cmp_din_d, cmp_din_q;
  logic [63:0]   tim_din_d, tim_din_q;
  logic          cmp_wr_d,  cmp_wr_q;
  logic          tim_wr_d,  tim_wr_q;
  logic [63:0]   mirror_d,  mirror_q;
  logic [PW-1:0] presc_d,   presc_q;
  logic [31:0]   snap_d,    snap_q;
  logic          snap_vld_d, snap_vld_q;

  assign mmio_hit   = (i_addr[31:5] == MMIO_BASE[31:5]);
  assign ram_hit    = !mmio_hit;
  assign mmio_we    = i_wr_en && mmio_hit && (|i_wr_mask);
  assign off        = i_addr[4:0];
  assign sel_msip   = mmio_hit && (off == 5'h00);
  assign sel_cmp_lo = mmio_hit && (off == 5'h08);
  assign sel_cmp_hi = mmio_hit && (off == 5'h0C);
  assign sel_tim_lo = mmio_hit && (off == 5'h10);
  assign sel_tim_hi = mmio_hit && (off == 5'h14);
  assign tick       = (presc_q == PS_LAST);

  always_comb begin
    msip_d     = msip_q;
    cmp_lo_d   = cmp_lo_q;
    cmp_hi_d   = cmp_hi_q;
    tim_lo_d   = tim_lo_q;
    tim_hi_d   = tim_hi_q;
    cmp_din_d  = cmp_din_q;
    tim_din_d  = tim_din_q;
    cmp_wr_d   = 1'b0;
    tim_wr_d   = 1'b0;
    mirror_d   = mirror_q;
    presc_d    = presc_q;
    snap_d     = snap_q;
    snap_vld_d = sel_tim_lo;
    rd_data_d  = '0;

    if (mmio_we) begin
      unique case (1'b1)
        sel_msip:
          if (i_wr_mask[0]) msip_d = i_wr_data[0];
        sel_cmp_lo:
          cmp_lo_d = merge(cmp_lo_q, i_wr_data, i_wr_mask);
        sel_cmp_hi: begin
          cmp_hi_d  = merge(cmp_hi_q, i_wr_data, i_wr_mask);
          cmp_din_d = {cmp_hi_d, cmp_lo_q};
          cmp_wr_d  = 1'b1;
        end
        sel_tim_lo:
          tim_lo_d = merge(tim_lo_q, i_wr_data, i_wr_mask);
        sel_tim_hi: begin
          tim_hi_d  = merge(tim_hi_q, i_wr_data, i_wr_mask);
          tim_din_d = {tim_hi_d, tim_lo_q};
          tim_wr_d  = 1'b1;
        end
        default: ;
      endcase
    end

    // Mirror loads on the same edge the core samples the pulse,
    // so both counters restart in lockstep.
    if (tim_wr_q) begin
      mirror_d = tim_din_q;
      presc_d  = '0;
    end else if (tick) begin
      mirror_d = mirror_q + 64'd1;
      presc_d  = '0;
    end else begin
      presc_d  = presc_q + PW'(1);
    end

    // Lo read latches the matching hi half for a coherent pair.
    if (sel_tim_lo) snap_d = mirror_q[63:32];

    unique case (1'b1)
      ram_hit:    rd_data_d = ram_rd;
      sel_msip:   rd_data_d = {31'd0, msip_q};
      sel_cmp_lo: rd_data_d = cmp_din_q[31:0];
      sel_cmp_hi: rd_data_d = cmp_din_q[63:32];
      sel_tim_lo: rd_data_d = mirror_q[31:0];
      sel_tim_hi: rd_data_d = snap_vld_q ? snap_q
                                         : mirror_q[63:32];
      default:    rd_data_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      msip_q     <= 1'b0;
      cmp_lo_q   <= '1;
      cmp_hi_q   <= '1;
      tim_lo_q   <= '0;
      tim_hi_q   <= '0;
      cmp_din_q  <= '1;
      tim_din_q  <= '0;
      cmp_wr_q   <= 1'b0;
      tim_wr_q   <= 1'b0;
      mirror_q   <= '0;
      presc_q    <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      cmp_lo_q   <= cmp_lo_d;
      cmp_hi_q   <= cmp_hi_d;
      tim_lo_q   <= tim_lo_d;
      tim_hi_q   <= tim_hi_d;
      cmp_din_q  <= cmp_din_d;
      tim_din_q  <= tim_din_d;
      cmp_wr_q   <= cmp_wr_d;
      tim_wr_q   <= tim_wr_d;
      mirror_q   <= mirror_d;
      presc_q    <= presc_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  assign o_mtime_wr           = tim_wr_q;
  assign o_mtimecmp_wr        = cmp_wr_q;
  assign o_mtime_din          = tim_din_q;
  assign o_mtimecmp_din       = cmp_din_q;
  assign o_software_interrupt = msip_q;

`else

  assign ram_hit = 1'b1;

  always_comb begin
    rd_data_d = ram_rd;
  end

  assign o_mtime_wr           = 1'b0;
  assign o_mtimecmp_wr        = 1'b0;
  assign o_mtime_din          = '0;
  assign o_mtimecmp_din       = '1;
  assign o_software_interrupt = 1'b0;

`endif

endmodule

// File: tb/tb_rv32i_mem_responder.sv
// Directed bench for rv32i_mem_responder.
// Timer scenarios run only when MEM_RESPONDER_TIMER_EN is defined.
module tb_rv32i_mem_responder;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic [31:0] rdata;
  logic        mtime_wr;
  logic        mtimecmp_wr;
  logic [63:0] mtime_din;
  logic [63:0] mtimecmp_din;
  logic        swi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_mem_responder dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_addr               (addr),
    .i_wr_data            (wdata),
    .i_wr_mask            (wmask),
    .i_wr_en              (wen),
    .o_rd_data            (rdata),
    .o_mtime_wr           (mtime_wr),
    .o_mtimecmp_wr        (mtimecmp_wr),
    .o_mtime_din          (mtime_din),
    .o_mtimecmp_din       (mtimecmp_din),
    .o_software_interrupt (swi)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0]  m);
    addr  = a;
    wdata = d;
    wmask = m;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
    wmask = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    addr = a;
    wen  = 1'b0;
    step();
    d = rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    addr  = '0;
    wdata = '0;
    wmask = '0;
    wen   = 1'b0;
    repeat (3) step();
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rd: got %h want 0", rdata);
    end
    checks++;
    rst_n = 1'b1;
    #1;
    if (mtime_wr !== 1'b0 || mtimecmp_wr !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulse: got %b%b want 00",
               mtime_wr, mtimecmp_wr);
    end
    checks++;
    if (mtime_din !== 64'h0) begin
      errors++;
      $display("FAIL rst_mtime_din: got %h want 0", mtime_din);
    end
    checks++;
    if (mtimecmp_din !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL rst_cmp_din: got %h want all ones",
               mtimecmp_din);
    end
    checks++;
    if (swi !== 1'b0) begin
      errors++;
      $display("FAIL rst_swi: got %b want 0", swi);
    end
    checks++;
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h40, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h40, 32'h0000_5500, 4'b0010);
    rd(32'h40, v);
    if (v !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL ram_mask: got %h want DEAD55EF", v);
    end
    checks++;
    wr(32'h40, 32'h0123_4567, 4'b0000);
    rd(32'h40, v);
    if (v !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL ram_mask0: got %h want DEAD55EF", v);
    end
    checks++;
    // 1024 words alias every 0x1000 bytes
    wr(32'h1040, 32'h1234_5678, 4'b1111);
    rd(32'h40, v);
    if (v !== 32'h1234_5678) begin
      errors++;
      $display("FAIL ram_alias: got %h want 12345678", v);
    end
    checks++;
    wr(32'h40, 32'hAABB_CCDD, 4'b1111);
    if (rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL ram_rbw: got %h want 12345678", rdata);
    end
    checks++;
    rd(32'h40, v);
    if (v !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL ram_after_rbw: got %h want AABBCCDD", v);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(32'h44, 32'h1111_1111, 4'b1111);
    wr(32'h48, 32'h2222_2222, 4'b1111);
    wr(32'h4C, 32'h3333_3333, 4'b1000);
    rd(32'h44, v);
    if (v !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_44: got %h want 11111111", v);
    end
    checks++;
    rd(32'h48, v);
    if (v !== 32'h2222_2222) begin
      errors++;
      $display("FAIL b2b_48: got %h want 22222222", v);
    end
    checks++;
    wr(32'h4C, 32'h0000_0044, 4'b0001);
    rd(32'h4C, v);
    if (v[31:24] !== 8'h33 || v[7:0] !== 8'h44) begin
      errors++;
      $display("FAIL b2b_4c: got %h want 33xxxx44", v);
    end
    checks++;
  endtask

`ifdef MEM_RESPONDER_TIMER_EN

  task automatic test_mtimecmp();
    logic [31:0] v;
    wr(MB + 32'h08, 32'h0000_1000, 4'b1111);
    if (mtimecmp_wr !== 1'b0 ||
        mtimecmp_din !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL cmp_lo_only: got %b %h want 0 all ones",
               mtimecmp_wr, mtimecmp_din);
    end
    checks++;
    wr(MB + 32'h0C, 32'h0000_0002, 4'b1111);
    if (mtimecmp_wr !== 1'b1 ||
        mtimecmp_din !== 64'h0000_0002_0000_1000) begin
      errors++;
      $display("FAIL cmp_commit: got %b %h want 1 0000000200001000",
               mtimecmp_wr, mtimecmp_din);
    end
    checks++;
    step();
    if (mtimecmp_wr !== 1'b0 ||
        mtimecmp_din !== 64'h0000_0002_0000_1000) begin
      errors++;
      $display("FAIL cmp_one_pulse: got %b %h want 0 0000000200001000",
               mtimecmp_wr, mtimecmp_din);
    end
    checks++;
    rd(MB + 32'h0C, v);
    if (v !== 32'h2) begin
      errors++;
      $display("FAIL cmp_rd_hi: got %h want 2", v);
    end
    checks++;
    wr(MB + 32'h08, 32'h0000_5555, 4'b1111);
    rd(MB + 32'h08, v);
    if (v !== 32'h0000_1000) begin
      errors++;
      $display("FAIL cmp_rd_committed: got %h want 1000", v);
    end
    checks++;
    wr(MB + 32'h0C, 32'h0000_AB00, 4'b0010);
    if (mtimecmp_wr !== 1'b1 ||
        mtimecmp_din !== 64'h0000_AB02_0000_5555) begin
      errors++;
      $display("FAIL cmp_hi_masked: got %b %h want 1 0000AB0200005555",
               mtimecmp_wr, mtimecmp_din);
    end
    checks++;
    wr(MB + 32'h0C, 32'h0000_0003, 4'b1111);
    if (mtimecmp_din !== 64'h0000_0003_0000_5555) begin
      errors++;
      $display("FAIL cmp_hi_only: got %h want 0000000300005555",
               mtimecmp_din);
    end
    checks++;
  endtask

  task automatic test_mtime_snapshot();
    logic [31:0] v;
    wr(MB + 32'h10, 32'hFFFF_FFFF, 4'b1111);
    wr(MB + 32'h14, 32'h0000_0000, 4'b1111);
    if (mtime_wr !== 1'b1 ||
        mtime_din !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL tim_commit: got %b %h want 1 00000000FFFFFFFF",
               mtime_wr, mtime_din);
    end
    checks++;
    step();
    if (mtime_wr !== 1'b0 ||
        mtime_din !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL tim_one_pulse: got %b %h want 0 00000000FFFFFFFF",
               mtime_wr, mtime_din);
    end
    checks++;
    repeat (99) step();
    // Last cycle before the first tick after the load.
    rd(MB + 32'h10, v);
    if (v !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL tim_pre_tick: got %h want FFFFFFFF", v);
    end
    checks++;
    rd(MB + 32'h14, v);
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL tim_snapshot: got %h want 0", v);
    end
    checks++;
    rd(MB + 32'h14, v);
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL tim_hi_live: got %h want 1", v);
    end
    checks++;
    rd(MB + 32'h10, v);
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL tim_lo_wrap: got %h want 0", v);
    end
    checks++;
  endtask

  task automatic test_snapshot_clear();
    logic [31:0] v;
    wr(MB + 32'h10, 32'hFFFF_FFFF, 4'b1111);
    wr(MB + 32'h14, 32'h0000_0000, 4'b1111);
    repeat (99) step();
    rd(MB + 32'h10, v);
    if (v !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL snap_lo: got %h want FFFFFFFF", v);
    end
    checks++;
    rd(MB, v);
    rd(MB + 32'h14, v);
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL snap_cleared: got %h want 1", v);
    end
    checks++;
  endtask

  task automatic test_msip();
    logic [31:0] v;
    wr(MB, 32'h1, 4'b1111);
    if (swi !== 1'b1) begin
      errors++;
      $display("FAIL msip_set: got %b want 1", swi);
    end
    checks++;
    rd(MB, v);
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL msip_rd: got %h want 1", v);
    end
    checks++;
    wr(MB, 32'h0, 4'b1110);
    if (swi !== 1'b1) begin
      errors++;
      $display("FAIL msip_masked: got %b want 1", swi);
    end
    checks++;
    wr(MB, 32'h0, 4'b1111);
    if (swi !== 1'b0) begin
      errors++;
      $display("FAIL msip_clr: got %b want 0", swi);
    end
    checks++;
    wr(MB + 32'h04, 32'hFFFF_FFFF, 4'b1111);
    rd(MB + 32'h04, v);
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL mmio_hole: got %h want 0", v);
    end
    checks++;
  endtask

  task automatic test_reset_mid_commit();
    logic [31:0] v;
    wr(MB, 32'h1, 4'b1111);
    wr(MB + 32'h10, 32'h0000_0005, 4'b1111);
    wr(MB + 32'h14, 32'h0000_0007, 4'b1111);
    rst_n = 1'b0;
    #1;
    if (mtime_wr !== 1'b0 || mtime_din !== 64'h0) begin
      errors++;
      $display("FAIL rstm_pulse: got %b %h want 0 0",
               mtime_wr, mtime_din);
    end
    checks++;
    if (mtimecmp_din !== 64'hFFFF_FFFF_FFFF_FFFF || swi !== 1'b0) begin
      errors++;
      $display("FAIL rstm_cmp_swi: got %h %b want all ones 0",
               mtimecmp_din, swi);
    end
    checks++;
    step();
    step();
    rst_n = 1'b1;
    rd(MB + 32'h14, v);
    if (v !== 32'h0 || mtime_wr !== 1'b0) begin
      errors++;
      $display("FAIL rstm_hi: got %h %b want 0 0", v, mtime_wr);
    end
    checks++;
    rd(MB + 32'h10, v);
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL rstm_lo: got %h want 0", v);
    end
    checks++;
    rd(MB + 32'h0C, v);
    if (v !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rstm_cmp_rd: got %h want FFFFFFFF", v);
    end
    checks++;
  endtask

`else

  task automatic test_no_timer();
    logic [31:0] v;
    wr(MB, 32'h1, 4'b1111);
    if (swi !== 1'b0 || mtime_wr !== 1'b0 ||
        mtimecmp_wr !== 1'b0) begin
      errors++;
      $display("FAIL nt_tied: got %b%b%b want 000",
               swi, mtime_wr, mtimecmp_wr);
    end
    checks++;
    wr(MB + 32'h0C, 32'h2, 4'b1111);
    if (mtimecmp_din !== 64'hFFFF_FFFF_FFFF_FFFF ||
        mtime_din !== 64'h0) begin
      errors++;
      $display("FAIL nt_din: got %h %h want all ones 0",
               mtimecmp_din, mtime_din);
    end
    checks++;
    rd(32'h0, v);
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL nt_ram_alias: got %h want 1", v);
    end
    checks++;
    rd(MB + 32'h0C, v);
    if (v !== 32'h2) begin
      errors++;
      $display("FAIL nt_ram_c: got %h want 2", v);
    end
    checks++;
  endtask

`endif

  initial begin
    test_reset();
    test_ram();
    test_back_to_back();
`ifdef MEM_RESPONDER_TIMER_EN
    test_mtimecmp();
    test_mtime_snapshot();
    test_snapshot_clear();
    test_msip();
    test_reset_mid_commit();
`else
    test_no_timer();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
